// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle RV32I load/store controller sitting between the
// execute stage and a 32-bit word-organised data memory. One request at a time;
// sub-word stores are done as read-modify-write on the word memory, and loads
// return sign- or zero-extended data with a single-cycle response pulse.
module load_store_unit #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;      // byte offset of the request inside its word
  logic [15:0] store_lo_q;  // only the low half of store data is needed after accept

  // A request is rejected for an illegal width code, a misaligned address
  // or a word index outside the attached memory.
  function automatic logic req_error(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr);
    logic illegal;
    logic misaligned;
    logic out_of_range;
    if (we) begin
      illegal = (f3 > 3'b010);
    end else begin
      illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    // Low two funct3 bits encode the access size for both loads and stores.
    misaligned = ((f3[1:0] == 2'b01) && addr[0]) ||
                 ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    out_of_range = ({2'b00, addr[31:2]} >= DEPTH_W);
    return illegal || misaligned || out_of_range;
  endfunction

  // Pick the addressed byte/halfword out of a memory word and extend it.
  function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                               input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane of the old word with the new store data.
  function automatic logic [31:0] store_merge(input logic is_half,
                                              input logic [1:0] lane,
                                              input logic [31:0] old,
                                              input logic [15:0] wd);
    logic [31:0] r;
    r = old;
    if (is_half) begin
      if (lane[1]) begin
        r[31:16] = wd;
      end else begin
        r[15:0] = wd;
      end
    end else begin
      r[{lane, 3'b000} +: 8] = wd[7:0];
    end
    return r;
  endfunction

  // Ready is combinational so that it drops the moment reset is raised.
  assign req_ready = (state == IDLE) && !rst;

  // Controller FSM; every memory and response output is a register so that
  // reset clears them asynchronously and aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      lane_q     <= 2'b00;
      store_lo_q <= 16'h0000;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      resp_err   <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= 32'h0000_0000;
      mem_wdata  <= 32'h0000_0000;
    end else begin
      resp_valid <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= 32'h0000_0000;
      mem_wdata  <= 32'h0000_0000;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            funct3_q   <= req_funct3;
            lane_q     <= req_addr[1:0];
            store_lo_q <= req_wdata[15:0];
            if (req_error(req_we, req_funct3, req_addr)) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0000_0000;
            end else if (req_we && (req_funct3 == 3'b010)) begin
              // Full-word store needs no read of the old contents.
              state     <= WR;
              mem_write <= 1'b1;
              mem_addr  <= {2'b00, req_addr[31:2]};
              mem_wdata <= req_wdata;
            end else begin
              // Loads and sub-word stores both start by reading the word.
              state    <= RD;
              mem_read <= 1'b1;
              mem_addr <= {2'b00, req_addr[31:2]};
            end
          end else begin
            state <= IDLE;
          end
        end
        RD: begin
          if (we_q) begin
            state     <= WR;
            mem_write <= 1'b1;
            mem_addr  <= mem_addr;
            mem_wdata <= store_merge(funct3_q[0], lane_q, mem_rdata, store_lo_q);
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_extract(funct3_q, lane_q, mem_rdata);
          end
        end
        WR: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0000_0000;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios followed by
// randomized requests, checked against a byte-addressed reference memory.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain byte-addressed memory covering the 64 words.
  logic [7:0]  ref_bytes [0:255];
  // Attached word memory that the DUT actually reads and writes.
  logic [31:0] tb_mem [0:63];
  logic        mem_load;

  // Values driven on the request inputs while the DUT is busy.
  logic        busy_valid;
  logic        busy_we;
  logic [2:0]  busy_f3;
  logic [31:0] busy_addr;
  logic [31:0] busy_wdata;

  load_store_unit #(.DEPTH(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_word(input int unsigned w);
    return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
  endfunction

  assign mem_rdata = mem_read ? tb_mem[mem_addr[5:0]] : 32'h0000_0000;

  // Word memory: preloaded from the reference during reset, then written by the DUT.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int w = 0; w < 64; w++) tb_mem[w] <= ref_word(w);
    end else if (mem_write) begin
      tb_mem[mem_addr[5:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request at a posedge+1 point in IDLE, check every cycle until the
  // response and the cycle after it. Returns the observed response data.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rdata_obs);
    logic [31:0] widx;
    int          n;
    bit          legal, err;
    int          lat, rd_cyc, wr_cyc;
    logic [31:0] exp_rdata, exp_wword;
    longint      v;
    widx  = addr >> 2;
    n     = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err   = !legal || ((addr % n) != 0) || (widx >= 64);
    exp_rdata = 32'h0;
    exp_wword = 32'h0;
    rd_cyc = 0;
    wr_cyc = 0;
    if (err) begin
      lat = 1;
    end else if (we) begin
      for (int k = 0; k < n; k++) ref_bytes[addr + k] = 8'(wd >> (8 * k));
      exp_wword = ref_word(widx);
      lat    = (n == 4) ? 2 : 3;
      rd_cyc = (n == 4) ? 0 : 1;
      wr_cyc = (n == 4) ? 1 : 2;
    end else begin
      v = 0;
      for (int k = 0; k < n; k++) v += longint'(ref_bytes[addr + k]) << (8 * k);
      if (f3[2] == 1'b0 && n < 4 && v >= (longint'(1) << (8 * n - 1)))
        v -= (longint'(1) << (8 * n));
      exp_rdata = v[31:0];
      lat    = 2;
      rd_cyc = 1;
    end

    chk("ready_before_accept", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      req_valid  = busy_valid;
      req_we     = busy_we;
      req_funct3 = busy_f3;
      req_addr   = busy_addr;
      req_wdata  = busy_wdata;
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, c == lat});
      chk("ready_busy", {31'b0, req_ready}, 32'd0);
      chk("mem_read", {31'b0, mem_read}, {31'b0, c == rd_cyc});
      chk("mem_write", {31'b0, mem_write}, {31'b0, c == wr_cyc});
      chk("mem_addr", mem_addr, (c == rd_cyc || c == wr_cyc) ? widx : 32'h0);
      chk("mem_wdata", mem_wdata, (c == wr_cyc) ? exp_wword : 32'h0);
      if (c == lat) begin
        chk("resp_err", {31'b0, resp_err}, {31'b0, err});
        chk("resp_rdata", resp_rdata, exp_rdata);
      end
    end
    rdata_obs = resp_rdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("resp_pulse_end", {31'b0, resp_valid}, 32'd0);
    chk("ready_after_resp", {31'b0, req_ready}, 32'd1);
    chk("rdata_held", resp_rdata, exp_rdata);
  endtask

  logic [31:0] obs;

  initial begin
    rst        = 1'b1;
    mem_load   = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    busy_valid = 1'b0;
    busy_we    = 1'b0;
    busy_f3    = 3'b000;
    busy_addr  = 32'h0;
    busy_wdata = 32'h0;
    for (int i = 0; i < 256; i++) ref_bytes[i] = 8'($urandom);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    mem_load = 1'b0;
    rst      = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

    // Directed word store then sub-word loads of the same word
    run_req(1'b1, 3'b010, 32'h40, 32'hDEADBEEF, obs);
    run_req(1'b0, 3'b000, 32'h41, 32'h0, obs);
    chk("lb_0x41", obs, 32'hFFFFFFBE);
    run_req(1'b0, 3'b100, 32'h41, 32'h0, obs);
    chk("lbu_0x41", obs, 32'h000000BE);
    run_req(1'b0, 3'b010, 32'h40, 32'h0, obs);
    chk("lw_0x40", obs, 32'hDEADBEEF);

    // SB with a second request (LH 0x42) held valid throughout the busy period
    busy_valid = 1'b1;
    busy_we    = 1'b0;
    busy_f3    = 3'b001;
    busy_addr  = 32'h42;
    busy_wdata = 32'h0;
    run_req(1'b1, 3'b000, 32'h42, 32'h00000012, obs);
    busy_valid = 1'b0;
    run_req(1'b0, 3'b001, 32'h42, 32'h0, obs);
    chk("lh_0x42", obs, 32'hFFFFDE12);
    run_req(1'b0, 3'b101, 32'h42, 32'h0, obs);
    chk("lhu_0x42", obs, 32'h0000DE12);

    // Rejected requests
    run_req(1'b0, 3'b010, 32'h42, 32'h0, obs);
    run_req(1'b1, 3'b001, 32'h43, 32'h5555AAAA, obs);
    run_req(1'b0, 3'b010, 32'h100, 32'h0, obs);
    run_req(1'b0, 3'b011, 32'h40, 32'h0, obs);
    run_req(1'b1, 3'b011, 32'h40, 32'h0, obs);
    run_req(1'b0, 3'b000, 32'hFFFFFFFC, 32'h0, obs);

    // Reset during the WR cycle of an SH aborts it without a write or response
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b001;
    req_addr   = 32'h42;
    req_wdata  = 32'h0000BEAD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_rd", {31'b0, mem_read}, 32'd1);
    @(posedge clk); #1;
    chk("abort_wr", {31'b0, mem_write}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_wr_drop", {31'b0, mem_write}, 32'd0);
    chk("abort_rd_low", {31'b0, mem_read}, 32'd0);
    chk("abort_ready_low", {31'b0, req_ready}, 32'd0);
    chk("abort_rdata_clr", resp_rdata, 32'h0);
    @(posedge clk); #1;
    chk("abort_no_resp", {31'b0, resp_valid}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_no_resp2", {31'b0, resp_valid}, 32'd0);
    chk("abort_ready_back", {31'b0, req_ready}, 32'd1);
    run_req(1'b0, 3'b001, 32'h42, 32'h0, obs);
    chk("lh_after_abort", obs, 32'hFFFFDE12);

    // Randomized requests with random activity on the inputs while busy
    for (int i = 0; i < 300; i++) begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_addr;
      busy_valid = 1'($urandom_range(0, 1));
      busy_we    = 1'($urandom_range(0, 1));
      busy_f3    = 3'($urandom_range(0, 7));
      busy_addr  = $urandom;
      busy_wdata = $urandom;
      r_we   = 1'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 32'h10F));
      run_req(r_we, r_f3, r_addr, $urandom, obs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store controller between the core's execute stage and the 32-bit word-organised data memory. It accepts one byte-addressed RV32I load or store request at a time and checks alignment, range and funct3. It performs byte and halfword stores as read-modify-write on the word memory. It returns sign- or zero-extended load data with a one-cycle response pulse.

## Interface
- DEPTH, 64, number of 32-bit words in the attached data memory; word index must be < DEPTH.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; equals (state==IDLE) && !rst.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  request rejected; valid with resp_valid.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_addr  out  32  word index {2'b00, req_addr[31:2]}.
- mem_wdata  out  32  to memory write_data.
- mem_rdata  in  32  from memory read_data; combinational, valid while mem_read=1.

## Operation
- FSM states are IDLE, RD, WR and RESP. Reset sets state=IDLE.
- Accept: req_valid && req_ready at a rising edge latches we, funct3, addr and wdata. Inputs are ignored while not IDLE.
- Error check at accept:
  - misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - out of range: addr[31:2] ≥ DEPTH.
  - illegal funct3: load 011/110/111, or store ≥011.
  - Any error → RESP with resp_err=1. No memory access.
- Load: IDLE→RD→RESP. In RD, mem_read=1 and mem_addr=index; mem_rdata is captured at the end of RD.
- Extraction: byte lane = addr[1:0] and half lane = addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- SW: IDLE→WR→RESP. In WR, mem_write=1 and mem_wdata=wdata.
- SB/SH: IDLE→RD→WR→RESP. RD captures the old word. WR writes the old word with only the addressed lane replaced by wdata[7:0] or wdata[15:0].
- RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no backpressure.
- Outside RD, mem_read=0. Outside WR, mem_write=0. mem_addr=0 in IDLE/RESP. mem_wdata=0 outside WR.
- mem_read and mem_write are never both 1 in the same cycle.

## Timing
- Cycle 0 is the accept edge. Responses occur at:
  - load: resp_valid in cycle 2.
  - SW: resp_valid in cycle 2.
  - SB/SH: resp_valid in cycle 3.
  - error: resp_valid in cycle 1.
- The earliest next accept is the cycle after RESP, so req_ready rises the cycle after resp_valid.
- Reset values: req_ready=0 while rst is high and 1 after release. resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation aborts immediately:
  - mem_write and mem_read drop asynchronously.
  - No resp_valid is generated for the aborted request.
  - The latched request is discarded.
- resp_rdata and resp_err are registered. They are held until the next RESP and are not cleared to 0 between responses.

## Test plan
- After reset, SW addr 0x40 wdata 0xDEADBEEF → cycle 1: mem_write=1, mem_addr=16, mem_wdata=0xDEADBEEF. Cycle 2: resp_valid=1, resp_err=0.
- LB 0x41 → resp_rdata 0xFFFFFFBE in cycle 2. LBU 0x41 → 0x000000BE. LW 0x40 → 0xDEADBEEF. mem_read=1 only in cycle 1.
- SB 0x42 wdata 0x00000012 → RD in cycle 1, WR in cycle 2 with mem_wdata=0xDE12BEEF, resp in cycle 3. A following LH 0x42 → 0xFFFFDE12 and LHU 0x42 → 0x0000DE12.
- Each of the following → resp_valid and resp_err=1 in cycle 1, resp_rdata=0, and mem_read/mem_write never asserted:
  - LW 0x42 (misaligned).
  - SH 0x43 (misaligned).
  - LW 0x100 (word 64, out of range).
  - load funct3 011 (illegal).
- Hold req_valid=1 with a second request during a busy SB → req_ready=0. The second request is accepted only in the cycle after resp_valid, and completes correctly.
- Assert rst during the WR cycle of an SH → mem_write falls within the same cycle, no resp_valid follows, and req_ready=1 one cycle after rst deasserts.
